// File: rtl/mc_main_control.sv
// mc_main_control: multicycle main control FSM for the MIPS datapath.
// Sequences Fetch / Decode / Execute / Memory / Writeback. It decodes the
// opcode once per instruction and stalls in FETCH, MEMRD and MEMWR until
// MemReady is high.
//
// Ports:
//   clk, reset  - single clock; synchronous active-high reset forces FETCH
//   Op          - opcode from the instruction register
//   MemReady    - memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst - datapath controls
//   IllegalOp   - unsupported opcode seen in DECODE (one cycle)
//   State       - current state encoding, for debug
//
// Optional feature: define ADDI_EN to support addi (states ADDIEX/ADDIWB).
// When it is undefined, addi is illegal and encodings 10/11 act as unused.
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] AluOp,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = '0;
    AluOp       = '0;
    AluSrcA     = 1'b0;
    AluSrcB     = '0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    IllegalOp   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        // IR and PC+4 are committed only on the cycle the fetch completes.
        IRWrite = MemReady;
        PCWrite = MemReady;
        state_d = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
        else if (Op == OP_RTYPE)        state_d = S_EXEC;
        else if (Op == OP_BEQ)          state_d = S_BRANCH;
        else if (Op == OP_J)            state_d = S_JUMP;
`ifdef ADDI_EN
        else if (Op == OP_ADDI)         state_d = S_ADDIEX;
`endif
        else begin
          IllegalOp = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        // Only lw/sw reach here, so anything that is not sw is a load.
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b10;
        state_d = S_RCOMP;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef ADDI_EN
      S_ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed testbench for mc_main_control: each step drives inputs, pushes the
// expected state/output vector to a scoreboard queue, then pops and compares.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, AluOp, AluSrcB;
  logic       AluSrcA, RegWrite, RegDst, IllegalOp;
  logic [3:0] State;

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000,
                         BAD = 6'b111111;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .AluOp(AluOp),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .IllegalOp(IllegalOp), .State(State)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  PCSource,AluOp,AluSrcA,AluSrcB,RegWrite,RegDst,IllegalOp}
  logic [16:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst, IllegalOp};

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t sb[$];

  function automatic logic [16:0] model(input logic [3:0] s, input logic [5:0] op,
                                        input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill;
    logic [1:0] pcs, aop, srcb;
    logic legal;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill} = '0;
    pcs = '0; aop = '0; srcb = '0;
    legal = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == J);
`ifdef ADDI_EN
    legal = legal || (op == ADDI);
`endif
    case (s)
      4'd0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin srcb = 2'b11; ill = !legal; end
      4'd2: begin srca = 1; srcb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; iord = 1; end
      4'd6: begin srca = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9: begin pcw = 1; pcs = 2'b10; end
`ifdef ADDI_EN
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: begin rw = 1; end
`endif
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rw, rd, ill};
  endfunction

  // One cycle: drive inputs, push expectation, compare, advance a clock.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic mr, input logic [3:0] est);
    exp_t e;
    reset = rst; Op = op; MemReady = mr;
    sb.push_back('{st: est, o: model(est, op, mr)});
    #1;
    e = sb.pop_front();
    tests++;
    assert (State === e.st) else begin
      fails++;
      $display("FAIL %s state: got %0d expected %0d", tag, State, e.st);
      $error("%s state got %0d expected %0d", tag, State, e.st);
    end
    tests++;
    assert (obs === e.o) else begin
      fails++;
      $display("FAIL %s outputs (state %0d): got %b expected %b", tag, e.st, obs, e.o);
      $error("%s outputs got %b expected %b", tag, obs, e.o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Op = LW; MemReady = 1'b1;
    @(posedge clk); #1;

    // Reset state, fetch stall (no IR/PC write), then lw: 0,1,2,3,4,0
    step("rst_fetch_stall", 0, LW, 0, 4'd0);
    step("lw_fetch",  0, LW, 1, 4'd0);
    step("lw_decode", 0, LW, 1, 4'd1);
    step("lw_memadr", 0, LW, 1, 4'd2);
    step("lw_memrd",  0, LW, 1, 4'd3);
    step("lw_memwb",  0, LW, 1, 4'd4);

    // R-type: 0,1,6,7
    step("rt_fetch",  0, RT, 1, 4'd0);
    step("rt_decode", 0, RT, 1, 4'd1);
    step("rt_exec",   0, RT, 1, 4'd6);
    step("rt_rcomp",  0, RT, 1, 4'd7);

    // sw with 3 stall cycles in MEMWR: MemWrite held for 4 cycles
    step("sw_fetch",  0, SW, 1, 4'd0);
    step("sw_decode", 0, SW, 1, 4'd1);
    step("sw_memadr", 0, SW, 1, 4'd2);
    step("sw_stall1", 0, SW, 0, 4'd5);
    step("sw_stall2", 0, SW, 0, 4'd5);
    step("sw_stall3", 0, SW, 0, 4'd5);
    step("sw_memwr",  0, SW, 1, 4'd5);

    // beq: 0,1,8
    step("beq_fetch",  0, BEQ, 1, 4'd0);
    step("beq_decode", 0, BEQ, 1, 4'd1);
    step("beq_branch", 0, BEQ, 1, 4'd8);

    // j: 0,1,9
    step("j_fetch",  0, J, 1, 4'd0);
    step("j_decode", 0, J, 1, 4'd1);
    step("j_jump",   0, J, 1, 4'd9);

    // Illegal opcode: one DECODE cycle with IllegalOp, then FETCH
    step("ill_fetch",  0, BAD, 1, 4'd0);
    step("ill_decode", 0, BAD, 1, 4'd1);

    // addi: legal only with the feature enabled
    step("addi_fetch",  0, ADDI, 1, 4'd0);
    step("addi_decode", 0, ADDI, 1, 4'd1);
`ifdef ADDI_EN
    step("addi_ex", 0, ADDI, 1, 4'd10);
    step("addi_wb", 0, ADDI, 1, 4'd11);
`endif

    // lw with MEMRD stall, reset asserted mid-stall
    step("rlw_fetch",  0, LW, 1, 4'd0);
    step("rlw_decode", 0, LW, 1, 4'd1);
    step("rlw_memadr", 0, LW, 1, 4'd2);
    step("rlw_stall",  0, LW, 0, 4'd3);
    step("rlw_rst",    1, LW, 0, 4'd3);
    step("rlw_after_rst", 0, LW, 1, 4'd0);
    step("rlw_restart",   0, LW, 1, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sits directly upstream of the ALU control decoder: drives its 2-bit AluOp (00 add, 01 subtract for beq, 10 R-type funct decode). Also drives every other datapath enable and mux select.
- Decodes Op[5:0] once per instruction. Sequences Fetch / Decode / Execute / Memory / Writeback.
- Stalls in memory states until the memory signals ready.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode (used only with ADDI_EN)

Ports:
clk  input  1  single clock, all state changes on rising edge
reset  input  1  synchronous, active-high; forces FETCH
Op  input  6  opcode from instruction register
MemReady  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
IRWrite  output  1  instruction register load
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
AluOp  output  2  to ALU control decoder
AluSrcA  output  1  0=PC, 1=A
AluSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
RegWrite  output  1  register file write
RegDst  output  1  0=rt, 1=rd
IllegalOp  output  1  unsupported opcode detected in DECODE
State  output  4  current state encoding, for debug

Behaviour:
- State register: 4 bits.
- Outputs are Moore (functions of State), except where "&MemReady" is shown below.
- Any output not listed for a state is 0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.

State outputs and transitions:
- FETCH:
  - Outputs: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00, IRWrite=MemReady, PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; otherwise go to DECODE.
- DECODE:
  - Outputs: AluSrcA=0, AluSrcB=11, AluOp=00.
  - Next state by Op: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDIEX (only with ADDI_EN).
  - Any other Op: IllegalOp=1 for this cycle, next state FETCH.
- MEMADR:
  - Outputs: AluSrcA=1, AluSrcB=10, AluOp=00.
  - Next state: lw -> MEMRD, sw -> MEMWR. Op is stable because IR is only written in FETCH.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Hold while MemReady=0; otherwise go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Hold while MemReady=0; otherwise go to FETCH.
- EXEC: AluSrcA=1, AluSrcB=00, AluOp=10; next state RCOMP.
- RCOMP: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
- JUMP: PCWrite=1, PCSource=10; next state FETCH.

Timing and boundary conditions:
- Cycle counts with MemReady held at 1: lw=5, sw=4, R-type=4, beq=3, j=3.
- Each cycle MemReady is 0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While stalled, request signals stay asserted and all write enables stay 0, except MemWrite, which stays asserted throughout MEMWR.
- Reset: on the clock edge where reset=1, State becomes FETCH. The following cycle shows FETCH outputs, with IRWrite and PCWrite equal to MemReady.
- Reset has priority over everything else, including mid-stall and mid-instruction. The partial instruction is abandoned with no further writes.
- Unused encodings 12–15: all outputs 0, next state FETCH.

Optional Feature:
ADDI_EN
- Defined:
  - DECODE on OP_ADDI -> ADDIEX.
  - ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00; next state ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
- Undefined:
  - OP_ADDI is illegal: IllegalOp=1 in DECODE, next state FETCH.
  - Encodings 10 and 11 behave as unused encodings.

Test Plan:
- Reset, then MemReady=1, Op=100011 -> State sequence 0,1,2,3,4,0. In state 4: RegWrite=1, MemtoReg=1, RegDst=0.
- Op=000000, MemReady=1 -> State 0,1,6,7,0. AluOp=10 in state 6. RegWrite=1 and RegDst=1 in state 7.
- Op=101011, MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, RegWrite stays 0, then State returns to 0.
- Op=000100 -> State 8 shows PCWriteCond=1, AluOp=01, PCSource=01. Op=000010 -> State 9 shows PCWrite=1, PCSource=10.
- Op=111111 -> IllegalOp=1 for exactly one cycle in DECODE, then FETCH. Op=001000 gives IllegalOp=1 without ADDI_EN, and State sequence 10,11,0 with ADDI_EN.
- Assert reset during MEMRD stall -> next cycle State=0, MemRead=1, IorD=0, RegWrite=0.
